// File: rtl/ahbl_test_sram_pkg.sv
// Shared AHB-Lite encodings and responder-internal types for the test SRAM model.
// Other AHB bench components import the htrans/hsize/hresp definitions from here.
package ahbl_test_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE = 2'd0,
    HTRANS_BUSY = 2'd1,
    HTRANS_NSEQ = 2'd2,
    HTRANS_SEQ  = 2'd3
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } sram_state_t;

  // Data-phase attributes captured at address-phase acceptance
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [2:0] size;
    logic [1:0] lo;
  } dph_t;

endpackage

// File: rtl/ahbl_test_sram_if.sv
// AHB-Lite bus bundle between an initiator (or bench) and the test SRAM responder.
interface ahbl_test_sram_if #(
  parameter int W_ADDR = 32
);
  logic              ahbl_hready;
  logic              ahbl_hready_resp;
  logic              ahbl_hresp;
  logic [W_ADDR-1:0] ahbl_haddr;
  logic              ahbl_hwrite;
  logic [1:0]        ahbl_htrans;
  logic [2:0]        ahbl_hsize;
  logic [2:0]        ahbl_hburst;
  logic [3:0]        ahbl_hprot;
  logic              ahbl_hmastlock;
  logic [31:0]       ahbl_hwdata;
  logic [31:0]       ahbl_hrdata;

  modport master (
    output ahbl_hready, ahbl_haddr, ahbl_hwrite, ahbl_htrans, ahbl_hsize,
           ahbl_hburst, ahbl_hprot, ahbl_hmastlock, ahbl_hwdata,
    input  ahbl_hready_resp, ahbl_hresp, ahbl_hrdata
  );

  modport slave (
    input  ahbl_hready, ahbl_haddr, ahbl_hwrite, ahbl_htrans, ahbl_hsize,
           ahbl_hburst, ahbl_hprot, ahbl_hmastlock, ahbl_hwdata,
    output ahbl_hready_resp, ahbl_hresp, ahbl_hrdata
  );
endinterface

// File: rtl/ahbl_byte_lanes.sv
// Transfer size + low address bits -> little-endian byte strobe and misalignment flag.
module ahbl_byte_lanes
  import ahbl_test_sram_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] strb,
  output logic       misaligned
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign strb[i] = (hsize == HSIZE_BYTE && addr == LANE)
                  || (hsize == HSIZE_HALF && addr[1] == LANE[1])
                  || (hsize == HSIZE_WORD);
  end

  assign misaligned = (hsize == HSIZE_HALF && addr[0])
                   || (hsize == HSIZE_WORD && addr != 2'd0);

endmodule

// File: rtl/ahbl_test_sram.sv
// AHB-Lite word-addressed SRAM responder with injectable wait states and ERROR responses.
// Used by simulation and formal benches of the core's instruction and data ports.
module ahbl_test_sram
  import ahbl_test_sram_pkg::*;
#(
  parameter int    DEPTH        = 1024,
  parameter int    W_ADDR       = 32,
  parameter string PRELOAD_FILE = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  ahbl_test_sram_if.slave ahbl,
  input  logic [3:0]      wait_cycles,
  input  logic            err_inject
);

  localparam int WW = $clog2(DEPTH);
  localparam int AW = WW + 2;

  sram_state_t   state, state_nxt;
  logic [3:0]    wait_cnt, wait_cnt_nxt;
  dph_t          dph;
  logic [WW-1:0] dph_addr;
  logic [3:0]    dph_strb;
  logic [3:0]    aph_strb_unused;
  logic          dph_misaligned_unused;
  logic          aph_misaligned, aph_oor, aph_err, accept, wr_en;
  logic [31:0]   mem [DEPTH];

  assign accept = ahbl.ahbl_hready
               && (ahbl.ahbl_htrans == HTRANS_NSEQ || ahbl.ahbl_htrans == HTRANS_SEQ);

  ahbl_byte_lanes u_aph_lanes (
    .hsize      (ahbl.ahbl_hsize),
    .addr       (ahbl.ahbl_haddr[1:0]),
    .strb       (aph_strb_unused),
    .misaligned (aph_misaligned)
  );

  // Anything beyond the array errors rather than aliasing onto low words
  if (W_ADDR > AW) begin : g_oor
    assign aph_oor = |ahbl.ahbl_haddr[W_ADDR-1:AW];
  end else begin : g_no_oor
    assign aph_oor = 1'b0;
  end

  assign aph_err = err_inject || (ahbl.ahbl_hsize > HSIZE_WORD) || aph_misaligned || aph_oor;

  // Errored transfers never open a read/write data phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph      <= '0;
      dph_addr <= '0;
    end else if (ahbl.ahbl_hready) begin
      dph.rd   <= accept && !ahbl.ahbl_hwrite && !aph_err;
      dph.wr   <= accept &&  ahbl.ahbl_hwrite && !aph_err;
      dph.size <= ahbl.ahbl_hsize;
      dph.lo   <= ahbl.ahbl_haddr[1:0];
      dph_addr <= ahbl.ahbl_haddr[AW-1:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (aph_err) begin
            state_nxt = ST_ERR1;
          end else if (wait_cycles != 4'd0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = wait_cycles;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) state_nxt = ST_IDLE;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ahbl.ahbl_hready_resp = !(state == ST_WAIT || state == ST_ERR1);
  assign ahbl.ahbl_hresp       = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign ahbl.ahbl_hrdata      = dph.rd ? mem[dph_addr] : 32'd0;

  ahbl_byte_lanes u_dph_lanes (
    .hsize      (dph.size),
    .addr       (dph.lo),
    .strb       (dph_strb),
    .misaligned (dph_misaligned_unused)
  );

  // Commit lands on the edge that also accepts a following read, so it sees new data
  assign wr_en = dph.wr && ahbl.ahbl_hready_resp;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dph_strb[i]) mem[dph_addr][8*i +: 8] <= ahbl.ahbl_hwdata[8*i +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ahbl.ahbl_hburst, ahbl.ahbl_hprot, ahbl.ahbl_hmastlock,
                       aph_strb_unused, dph_misaligned_unused};

`ifdef FORMAL
  a_stall_needs_dph: assert property (@(posedge clk) disable iff (!rst_n)
    !ahbl.ahbl_hready_resp |-> (dph.rd || dph.wr || state == ST_ERR1));
  a_err_first: assert property (@(posedge clk) disable iff (!rst_n)
    (ahbl.ahbl_hresp && !ahbl.ahbl_hready_resp) |=> (ahbl.ahbl_hresp && ahbl.ahbl_hready_resp));
  a_err_second: assert property (@(posedge clk) disable iff (!rst_n)
    (ahbl.ahbl_hresp && ahbl.ahbl_hready_resp) |-> $past(ahbl.ahbl_hresp && !ahbl.ahbl_hready_resp));
  a_wait_okay: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_WAIT) |-> !ahbl.ahbl_hresp);
`endif

endmodule

// File: tb/tb_ahbl_test_sram.sv
// Directed + randomized bench for ahbl_test_sram against a word-array reference model.
module tb_ahbl_test_sram;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] wait_cycles = '0;
  logic       err_inject = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  ahbl_test_sram_if #(.W_ADDR(32)) bus ();
  assign bus.ahbl_hready = bus.ahbl_hready_resp;

  ahbl_test_sram #(.DEPTH(DEPTH), .W_ADDR(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ahbl        (bus),
    .wait_cycles (wait_cycles),
    .err_inject  (err_inject)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] s, input logic inj);
    if (inj || s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
    return a >= 32'(DEPTH * 4);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int b;
    for (int k = 0; k < (1 << s); k++) begin
      b = int'(a % 4) + k;
      model_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Caller is at a negedge where the previous data phase is in its last cycle (or bus idle)
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [3:0] waits, input logic inj,
                      output logic [31:0] rdata, output int low, output int errc, output bit to);
    bus.ahbl_htrans = 2'd2;
    bus.ahbl_haddr  = addr;
    bus.ahbl_hwrite = wr;
    bus.ahbl_hsize  = size;
    wait_cycles     = waits;
    err_inject      = inj;
    @(posedge clk);
    @(negedge clk);
    bus.ahbl_htrans = 2'($urandom_range(0, 1));
    bus.ahbl_haddr  = $urandom;
    bus.ahbl_hwrite = 1'($urandom);
    bus.ahbl_hsize  = 3'($urandom);
    bus.ahbl_hwdata = wdata;
    wait_cycles     = 4'($urandom);
    err_inject      = 1'($urandom);
    low = 0; errc = 0; to = 1'b1; rdata = '0;
    for (int c = 0; c < 40; c++) begin
      if (bus.ahbl_hresp) errc++;
      if (bus.ahbl_hready_resp) begin
        rdata = bus.ahbl_hrdata;
        to = 1'b0;
        break;
      end
      low++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] waits,
                     input logic inj, output logic [31:0] rdata);
    bit e, to;
    int low, errc;
    e = model_err(addr, size, inj);
    xfer(wr, addr, size, wdata, waits, inj, rdata, low, errc, to);
    chk({tag, "_timeout"}, 32'(to), 32'd0);
    chk({tag, "_stall"}, 32'(low), e ? 32'd1 : 32'(waits));
    chk({tag, "_errcyc"}, 32'(errc), e ? 32'd2 : 32'd0);
    chk({tag, "_rdata"}, rdata, (!e && !wr) ? model_mem[addr[9:2]] : 32'd0);
    if (!e && wr) model_write(addr, size, wdata);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic [2:0]  s;
    logic [3:0]  w;
    logic        wr, inj;
    int          low;
    bit          to;

    bus.ahbl_htrans = 2'd0; bus.ahbl_haddr = '0; bus.ahbl_hwrite = 1'b0;
    bus.ahbl_hsize = 3'd2; bus.ahbl_hburst = '0; bus.ahbl_hprot = '0;
    bus.ahbl_hmastlock = 1'b0; bus.ahbl_hwdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_hready", bus.ahbl_hready_resp, 32'd1);
    chk("rst_hresp", bus.ahbl_hresp, 32'd0);
    chk("rst_hrdata", bus.ahbl_hrdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i <= 16; i++) run("init", 1'b1, 32'(i * 4), 3'd2, $urandom, 4'd0, 1'b0, rd);
    run("init_top", 1'b1, 32'(DEPTH * 4 - 4), 3'd2, $urandom, 4'd0, 1'b0, rd);

    // word write then immediately pipelined read
    run("w_dead", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'd0, 1'b0, rd);
    run("r_dead", 1'b0, 32'h10, 3'd2, 32'h0, 4'd0, 1'b0, rd);
    chk("dead_value", rd, 32'hDEADBEEF);

    // sub-word merges on lanes, junk in unselected lanes
    run("w_base", 1'b1, 32'h10, 3'd2, 32'h11223344, 4'd0, 1'b0, rd);
    run("w_byte", 1'b1, 32'h13, 3'd0, 32'hAA5A5A5A, 4'd0, 1'b0, rd);
    run("r_byte", 1'b0, 32'h10, 3'd2, 32'h0, 4'd0, 1'b0, rd);
    chk("byte_merge", rd, 32'hAA223344);
    run("w_half", 1'b1, 32'h12, 3'd1, 32'hBEEF7777, 4'd0, 1'b0, rd);
    run("r_half", 1'b0, 32'h10, 3'd1, 32'h0, 4'd0, 1'b0, rd);
    chk("half_merge", rd, 32'hBEEF3344);

    // waited read with a pipelined NSEQ held behind it
    run("w_cafe", 1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 4'd0, 1'b0, rd);
    bus.ahbl_htrans = 2'd2; bus.ahbl_haddr = 32'h20; bus.ahbl_hwrite = 1'b0;
    bus.ahbl_hsize = 3'd2; wait_cycles = 4'd3; err_inject = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.ahbl_haddr = 32'h10; wait_cycles = 4'd0;
    low = 0; to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.ahbl_hready_resp) begin to = 1'b0; break; end
      chk("pipe_wait_hresp", bus.ahbl_hresp, 32'd0);
      low++;
      @(negedge clk);
    end
    chk("pipe_timeout", 32'(to), 32'd0);
    chk("pipe_low", 32'(low), 32'd3);
    chk("pipe_rdata", bus.ahbl_hrdata, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    bus.ahbl_htrans = 2'd0;
    chk("pipe_nseq_hready", bus.ahbl_hready_resp, 32'd1);
    chk("pipe_nseq_rdata", bus.ahbl_hrdata, model_mem[4]);

    // error responses leave memory alone and never alias
    run("w_zero", 1'b1, 32'h0, 3'd2, 32'h0BADF00D, 4'd0, 1'b0, rd);
    run("r_misal", 1'b0, 32'h2, 3'd2, 32'h0, 4'd2, 1'b0, rd);
    run("w_oor", 1'b1, 32'(DEPTH * 4), 3'd2, 32'hFFFFFFFF, 4'd0, 1'b0, rd);
    run("w_halfmis", 1'b1, 32'h11, 3'd1, 32'hFFFFFFFF, 4'd0, 1'b0, rd);
    run("r_size3", 1'b0, 32'h10, 3'd3, 32'h0, 4'd0, 1'b0, rd);
    run("r_zero", 1'b0, 32'h0, 3'd2, 32'h0, 4'd0, 1'b0, rd);
    chk("no_alias", rd, 32'h0BADF00D);

    run("w_55", 1'b1, 32'h40, 3'd2, 32'h55, 4'd0, 1'b0, rd);
    run("w_inj", 1'b1, 32'h40, 3'd2, 32'h12345678, 4'd1, 1'b1, rd);
    run("r_55", 1'b0, 32'h40, 3'd2, 32'h0, 4'd0, 1'b0, rd);
    chk("inj_kept", rd, 32'h55);

    // reset while a waited write still has two stall cycles to go
    run("w_1111", 1'b1, 32'h30, 3'd2, 32'h1111, 4'd0, 1'b0, rd);
    bus.ahbl_htrans = 2'd2; bus.ahbl_haddr = 32'h30; bus.ahbl_hwrite = 1'b1;
    bus.ahbl_hsize = 3'd2; wait_cycles = 4'd4; err_inject = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.ahbl_htrans = 2'd0; bus.ahbl_hwdata = 32'h2222;
    chk("rstw_low1", bus.ahbl_hready_resp, 32'd0);
    @(negedge clk);
    chk("rstw_low2", bus.ahbl_hready_resp, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_hready", bus.ahbl_hready_resp, 32'd1);
    chk("rstw_hresp", bus.ahbl_hresp, 32'd0);
    chk("rstw_hrdata", bus.ahbl_hrdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("r_1111", 1'b0, 32'h30, 3'd2, 32'h0, 4'd0, 1'b0, rd);
    chk("rst_dropped", rd, 32'h1111);

    for (int n = 0; n < 150; n++) begin
      a   = ($urandom_range(0, 9) == 0) ? 32'(DEPTH * 4 - 4 + $urandom_range(0, 12))
                                        : 32'($urandom_range(0, 67));
      s   = 3'($urandom_range(0, 4));
      wr  = 1'($urandom_range(0, 1));
      w   = 4'($urandom_range(0, 3));
      inj = ($urandom_range(0, 7) == 0);
      run("rand", wr, a, s, $urandom, w, inj, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
